// File: rtl/dm_arb.sv
// Data-memory arbiter between the CPU and a debug/loader port; the CPU wins ties.
// Optional DM_ARB_BURST_LIMIT_EN caps consecutive debug grants at BURST_MAX while the CPU waits.
module dm_arb #(
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [8:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_dmtype,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [8:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [2:0]  dbg_dmtype,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata,
    output logic        dm_we,
    output logic [8:0]  dm_addr,
    output logic [31:0] dm_din,
    output logic [2:0]  dm_dmtype,
    input  logic [31:0] dm_dout,
    output logic [1:0]  arb_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        DBG  = 2'd2
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   cpu_gnt_r;
    logic   dbg_gnt_r;
    logic   limit_hit_s;

    if ((BURST_MAX < 1) || (BURST_MAX > 15)) begin : g_burst_max_out_of_range
    end

`ifdef DM_ARB_BURST_LIMIT_EN
    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);
    localparam logic [3:0] BURST_SAT  = 4'(BURST_MAX);

    logic [3:0] burst_cnt_r;

    // Count consecutive debug-owned cycles; stops at BURST_MAX so a long idle-CPU burst cannot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt_r <= 4'd0;
        end else if (state_r != DBG) begin
            burst_cnt_r <= 4'd0;
        end else if (burst_cnt_r < BURST_SAT) begin
            burst_cnt_r <= burst_cnt_r + 4'd1;
        end else begin
            burst_cnt_r <= burst_cnt_r;
        end
    end

    // The current cycle is the BURST_MAX-th debug cycle (or later).
    assign limit_hit_s = (state_r == DBG) && (burst_cnt_r >= BURST_LAST);
`else
    assign limit_hit_s = 1'b0;
`endif

    function automatic state_t next_state_f(state_t cur, logic c_req, logic d_req, logic lim);
        state_t nxt;
        nxt = IDLE;
        case (cur)
            IDLE: begin
                if (c_req)      nxt = CPU;
                else if (d_req) nxt = DBG;
                else            nxt = IDLE;
            end
            CPU: begin
                if (c_req)      nxt = CPU;
                else if (d_req) nxt = DBG;
                else            nxt = IDLE;
            end
            DBG: begin
                if (lim && c_req) nxt = CPU;
                else if (d_req)   nxt = DBG;
                else if (c_req)   nxt = CPU;
                else              nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    assign next_state_s = next_state_f(state_r, cpu_req, dbg_req, limit_hit_s);

    // Ownership FSM; grants are registered copies of the state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cpu_gnt_r <= 1'b0;
            dbg_gnt_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cpu_gnt_r <= (next_state_s == CPU);
            dbg_gnt_r <= (next_state_s == DBG);
        end
    end

    // Steer the owner's access to memory; the write strobe needs a live request and no reset.
    always_comb begin
        dm_we     = 1'b0;
        dm_addr   = 9'd0;
        dm_din    = 32'd0;
        dm_dmtype = 3'd0;
        case (state_r)
            CPU: begin
                dm_we     = cpu_req & cpu_we & ~reset;
                dm_addr   = cpu_addr;
                dm_din    = cpu_wdata;
                dm_dmtype = cpu_dmtype;
            end
            DBG: begin
                dm_we     = dbg_req & dbg_we & ~reset;
                dm_addr   = dbg_addr;
                dm_din    = dbg_wdata;
                dm_dmtype = dbg_dmtype;
            end
            default: begin
                dm_we     = 1'b0;
                dm_addr   = 9'd0;
                dm_din    = 32'd0;
                dm_dmtype = 3'd0;
            end
        endcase
    end

    assign arb_state = state_r;
    assign cpu_gnt   = cpu_gnt_r;
    assign dbg_gnt   = dbg_gnt_r;
    assign cpu_stall = cpu_req & ~cpu_gnt_r & ~reset;
    assign cpu_rdata = cpu_gnt_r ? dm_dout : 32'd0;
    assign dbg_rdata = dbg_gnt_r ? dm_dout : 32'd0;

endmodule

// File: tb/tb_dm_arb.sv
// Scoreboard bench for dm_arb: stimulus queues expected granted accesses, a negedge monitor checks them.
module tb_dm_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [8:0]  cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata, dbg_wdata;
    logic [2:0]  cpu_dmtype, dbg_dmtype;
    logic        cpu_gnt, cpu_stall, dbg_gnt, dm_we;
    logic [31:0] cpu_rdata, dbg_rdata, dm_din, dm_dout;
    logic [8:0]  dm_addr;
    logic [2:0]  dm_dmtype;
    logic [1:0]  arb_state;

    logic [31:0] mem [0:127];
    int          wr_count = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

`ifdef DM_ARB_BURST_LIMIT_EN
    localparam int BURST_GNTS = 4;
`else
    localparam int BURST_GNTS = 8;
`endif
    localparam int EXP_WRITES = 3 + BURST_GNTS;

    typedef struct {
        bit          dbg;
        bit          we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  dmtype;
        bit          rd_chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    dm_arb #(.BURST_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_dmtype(cpu_dmtype), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_dmtype(dbg_dmtype), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dmtype(dm_dmtype),
        .dm_dout(dm_dout), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational read, write on the rising edge.
    assign dm_dout = mem[dm_addr[8:2]];
    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_addr[8:2]] <= dm_din;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit dbg, input bit we, input logic [8:0] a, input logic [31:0] wd,
                        input bit rc, input logic [31:0] rd);
        exp_t e;
        e.dbg = dbg; e.we = we; e.addr = a; e.wdata = wd; e.dmtype = 3'd2; e.rd_chk = rc; e.rdata = rd;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Monitor: every granted, requested cycle outside reset must match the next queued access.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && ((cpu_gnt && cpu_req) || (dbg_gnt && dbg_req))) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: cpu_gnt=%0b dbg_gnt=%0b with empty queue at %0t",
                         cpu_gnt, dbg_gnt, $time);
            end else begin
                e = sb_q.pop_front();
                check("owner_is_dbg", 32'(dbg_gnt), 32'(e.dbg));
                check("other_gnt", 32'(e.dbg ? cpu_gnt : dbg_gnt), 32'd0);
                check("dm_we", 32'(dm_we), 32'(e.we));
                check("dm_addr", 32'(dm_addr), 32'(e.addr));
                check("dm_din", dm_din, e.wdata);
                check("dm_dmtype", 32'(dm_dmtype), 32'(e.dmtype));
                check("other_rdata", e.dbg ? cpu_rdata : dbg_rdata, 32'd0);
                check("cpu_stall", 32'(cpu_stall), e.dbg ? 32'(cpu_req) : 32'd0);
                if (e.rd_chk) check("owner_rdata", e.dbg ? dbg_rdata : cpu_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h0AC; cpu_wdata = 32'h1111_1111; cpu_dmtype = 3'd2;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h0B0; dbg_wdata = 32'h2222_2222; dbg_dmtype = 3'd2;

        // Reset held two cycles with both requesters active
        repeat (2) @(posedge clk);
        neg();
        check("rst_state", 32'(arb_state), 32'd0);
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("rst_dm_we", 32'(dm_we), 32'd0);
        step();
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;

        // CPU word store, then back-to-back read with no re-arbitration gap
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 32'hDEAD_BEEF;
        push(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF, 1'b0, 32'd0);
        neg();
        check("store_stall", 32'(cpu_stall), 32'd1);
        check("store_wait_gnt", 32'(cpu_gnt), 32'd0);
        step();
        neg();
        check("store_state", 32'(arb_state), 32'd1);
        step();
        cpu_we = 1'b0; cpu_wdata = 32'd0;
        push(1'b0, 1'b0, 9'h010, 32'd0, 1'b1, 32'hDEAD_BEEF);
        step();
        cpu_req = 1'b0;
        step();
        neg();
        check("idle_after_cpu", 32'(arb_state), 32'd0);

        // Tie from IDLE: CPU first, then debug with no idle gap
        step();
        cpu_req = 1'b1; cpu_addr = 9'h010;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h020; dbg_wdata = 32'hCAFE_F00D;
        push(1'b0, 1'b0, 9'h010, 32'd0, 1'b1, 32'hDEAD_BEEF);
        push(1'b1, 1'b1, 9'h020, 32'hCAFE_F00D, 1'b0, 32'd0);
        step();
        neg();
        check("tie_cpu_first", 32'(arb_state), 32'd1);
        step();
        cpu_req = 1'b0;
        neg();
        check("tie_no_gap", 32'(arb_state), 32'd1);
        step();
        neg();
        check("tie_dbg_gnt", 32'(dbg_gnt), 32'd1);
        step();
        dbg_req = 1'b0; dbg_we = 1'b0;
        step();
        neg();
        check("idle_after_dbg", 32'(arb_state), 32'd0);
        step();
        dbg_req = 1'b1; dbg_wdata = 32'd0;
        push(1'b1, 1'b0, 9'h020, 32'd0, 1'b1, 32'hCAFE_F00D);
        step();
        step();
        dbg_req = 1'b0;
        step();

        // Debug write burst with the CPU waiting from debug cycle 1
        step();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h040; dbg_wdata = 32'h1234_5678;
        for (int k = 0; k < BURST_GNTS; k++) push(1'b1, 1'b1, 9'h040, 32'h1234_5678, 1'b0, 32'd0);
        push(1'b0, 1'b0, 9'h010, 32'd0, 1'b1, 32'hDEAD_BEEF);
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h010;
        for (int k = 1; k <= BURST_GNTS; k++) begin
            neg();
            check("burst_dbg_gnt", 32'(dbg_gnt), 32'd1);
            check("burst_cpu_stall", 32'(cpu_stall), 32'd1);
            step();
        end
`ifdef DM_ARB_BURST_LIMIT_EN
        neg();
        check("burst_limit_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("burst_limit_dbg_off", 32'(dbg_gnt), 32'd0);
        step();
        cpu_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        step();
`else
        dbg_req = 1'b0; dbg_we = 1'b0;
        neg();
        check("starve_still_dbg", 32'(arb_state), 32'd2);
        check("starve_stall", 32'(cpu_stall), 32'd1);
        step();
        neg();
        check("starve_end_cpu_gnt", 32'(cpu_gnt), 32'd1);
        step();
        cpu_req = 1'b0;
        step();
`endif
        step();
        neg();
        check("idle_after_burst", 32'(arb_state), 32'd0);

        // Reset in the second cycle of a debug write burst
        step();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h020; dbg_wdata = 32'h55AA_55AA;
        push(1'b1, 1'b1, 9'h020, 32'h55AA_55AA, 1'b0, 32'd0);
        step();
        step();
        reset = 1'b1;
        neg();
        check("midrst_dm_we", 32'(dm_we), 32'd0);
        check("midrst_dm_addr", 32'(dm_addr), 32'h020);
        step();
        reset = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        neg();
        check("midrst_state", 32'(arb_state), 32'd0);
        check("midrst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("midrst_dm_addr_idle", 32'(dm_addr), 32'd0);
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h020;
        push(1'b0, 1'b0, 9'h020, 32'd0, 1'b1, 32'h55AA_55AA);
        step();
        step();
        cpu_req = 1'b0;
        step();
        step();

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("write_count", 32'(wr_count), 32'(EXP_WRITES));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arb.md
DM_ARB -- requirements
Module: dm_arb

Interface
REQ-001 Parameter BURST_MAX, default 4: maximum consecutive debug-grant cycles while the CPU waits; range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU data-memory access request (load or store).
REQ-005 cpu_we  input  1  CPU write enable, qualified by cpu_req.
REQ-006 cpu_addr  input  9  CPU byte address.
REQ-007 cpu_wdata  input  32  CPU store data.
REQ-008 cpu_dmtype  input  3  CPU access type (byte/half/word, signed/unsigned), passed to memory unchanged.
REQ-009 cpu_gnt  output  1  CPU owns the memory this cycle.
REQ-010 cpu_stall  output  1  cpu_req & ~cpu_gnt; freezes the CPU PC.
REQ-011 cpu_rdata  output  32  memory read data to the CPU.
REQ-012 dbg_req, dbg_we  input  1 each  debug/loader port request and write enable.
REQ-013 dbg_addr 9, dbg_wdata 32, dbg_dmtype 3  input  debug port address, data, access type.
REQ-014 dbg_gnt  output  1  debug port owns the memory this cycle.
REQ-015 dbg_rdata  output  32  memory read data to the debug port.
REQ-016 dm_we  output  1  data-memory write strobe.
REQ-017 dm_addr 9, dm_din 32, dm_dmtype 3  output  muxed address, write data, access type to data memory.
REQ-018 dm_dout  input  32  data-memory combinational read data.
REQ-019 arb_state  output  2  current FSM state: 0 IDLE, 1 CPU, 2 DBG.

Function
REQ-020 States: IDLE, CPU, DBG; registered; cpu_gnt = (state==CPU), dbg_gnt = (state==DBG).
REQ-021 IDLE: cpu_req -> CPU; else dbg_req -> DBG; else stay; both requesting -> CPU.
REQ-022 CPU: cpu_req held -> stay; cpu_req low and dbg_req high -> DBG directly; both low -> IDLE.
REQ-023 DBG: dbg_req held -> stay (subject to REQ-031); dbg_req low and cpu_req high -> CPU directly; both low -> IDLE.
REQ-024 Grant latency: one cycle from request to grant out of IDLE; zero-gap handover between owners.
REQ-025 Requesters hold req, we, addr, wdata and dmtype stable from request until the cycle their grant is seen.
REQ-026 Owner's addr/wdata/dmtype drive dm_*; dm_we = owner's we & ~reset; in IDLE, dm_we=0 and dm_addr/dm_din/dm_dmtype=0.
REQ-027 Memory write commits at the rising edge ending a granted cycle with we=1; exactly one write per granted write cycle.
REQ-028 cpu_rdata = dm_dout when cpu_gnt else 0; dbg_rdata = dm_dout when dbg_gnt else 0; valid in the grant cycle.
REQ-029 Requests without the matching grant never reach memory; a dropped request before grant is discarded silently.

Reset
REQ-030 With reset high at an edge: state=IDLE, burst counter=0; all outputs 0 from the following cycle; dm_we forced 0 during any reset-high cycle, including mid-burst.

Configuration
REQ-031 Macro DM_ARB_BURST_LIMIT_EN defined: 4-bit counter counts consecutive DBG cycles, cleared on leaving DBG; when count reaches BURST_MAX with cpu_req high, next state is CPU regardless of dbg_req; counter saturates when cpu_req low.
REQ-032 DM_ARB_BURST_LIMIT_EN undefined: no counter; DBG held while dbg_req high; CPU may starve.

Verification
REQ-033 Reset: reset=1 two cycles with both req high -> arb_state=0, cpu_gnt=dbg_gnt=0, dm_we=0.
REQ-034 CPU store: cpu_req=1,we=1,addr=0x010,wdata=0xDEADBEEF,dmtype=word -> cpu_stall=1 one cycle, then cpu_gnt=1, dm_we=1, dm_addr=0x010; readback returns 0xDEADBEEF.
REQ-035 Tie: both req from IDLE -> CPU granted first; CPU drops -> dbg_gnt next cycle, no IDLE gap.
REQ-036 Burst limit (macro on, BURST_MAX=4): dbg_req held, cpu_req raised in DBG cycle 1 -> dbg_gnt exactly 4 cycles, then cpu_gnt=1; macro off -> dbg_gnt persists, cpu_stall stays 1.
REQ-037 Reset mid-DBG write burst at addr 0x020 -> dm_we=0 in reset cycle, addr 0x020 unchanged, arb_state=0 next cycle.
